// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared constants, state encoding and address-step helpers for the decoder scan sequencer.
package decoder_scan_sequencer_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned PASS_W = 3;

  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(7);

  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;
  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Next code in the scan, modulo 8 in either direction.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic              dir);
    return (dir == DIR_DOWN) ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
  endfunction

  // True when stepping from addr crosses the 7/0 boundary.
  function automatic logic is_wrap(input logic [ADDR_W-1:0] addr, input logic dir);
    return (dir == DIR_DOWN) ? (addr == '0) : (addr == '1);
  endfunction

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Control and decoder-drive signals between a scan controller and the sequencer.
interface decoder_scan_sequencer_if;
  import decoder_scan_sequencer_pkg::*;

  logic              start;
  logic              stop;
  logic              dir;
  logic              mode;
  logic [ADDR_W-1:0] load_addr;
  logic              a2;
  logic              a1;
  logic              a0;
  logic              en;
  logic              step;
  logic              wrap;
  logic              done;
  logic              busy;

  modport master (
    output start, stop, dir, mode, load_addr,
    input  a2, a1, a0, en, step, wrap, done, busy
  );

  modport slave (
    input  start, stop, dir, mode, load_addr,
    output a2, a1, a0, en, step, wrap, done, busy
  );

endinterface

// File: rtl/decoder_scan_sequencer_tick_divider.sv
// Tick divider: counts enabled cycles 0..TICK_DIV-1; tick_c_o is combinational at terminal count.
module decoder_scan_sequencer_tick_divider #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c_o = enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps a 3-bit decoder select through all eight codes, each held TICK_DIV cycles,
// in continuous or single-pass mode, with registered step/wrap/done pulses.
module decoder_scan_sequencer
  import decoder_scan_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input logic                     clk,
  input logic                     reset,
  decoder_scan_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              dir_q, dir_d;
  logic              mode_q, mode_d;
  logic              en_q, en_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic start_acc_c;
  logic run_c;
  logic tick_c;
  logic clear_c;

  assign run_c       = (state_q == ST_RUN);
  assign start_acc_c = (state_q == ST_IDLE) && bus.start && !bus.stop;
  assign clear_c     = start_acc_c || tick_c;

  decoder_scan_sequencer_tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (clear_c),
    .enable_i (run_c),
    .tick_c_o (tick_c)
  );

  // Next-state and registered-output decode; stop outranks a same-cycle tick.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    en_d    = 1'b0;
    busy_d  = 1'b0;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_acc_c) begin
          state_d = ST_RUN;
          dir_d   = bus.dir;
          mode_d  = bus.mode;
          addr_d  = bus.load_addr;
          pass_d  = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          step_d  = 1'b1;
        end
      end
      ST_RUN: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
        if (bus.stop) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (tick_c) begin
          if ((mode_q == MODE_CONT) || (pass_q != PASS_LAST)) begin
            addr_d = next_addr(addr_q, dir_q);
            step_d = 1'b1;
            wrap_d = is_wrap(addr_q, dir_q);
            pass_d = (pass_q == PASS_LAST) ? pass_q : pass_q + PASS_W'(1);
          end else begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      pass_q  <= '0;
      dir_q   <= DIR_UP;
      mode_q  <= MODE_CONT;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign bus.a2   = addr_q[2];
  assign bus.a1   = addr_q[1];
  assign bus.a0   = addr_q[0];
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: four instances (TICK_DIV 1..4) share stimulus;
// per-cycle expectations are queued at drive time and compared against the selected instance.
module tb_decoder_scan_sequencer;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic       stop;
    logic       dir;
    logic       mode;
    logic [2:0] load;
  } stim_t;

  typedef struct packed {
    logic [2:0] addr;
    logic       en;
    logic       step;
    logic       wrap;
    logic       done;
    logic       busy;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       dir;
  logic       mode;
  logic [2:0] load;
  logic [1:0] sel;
  exp_t       obs [4];
  exp_t       sb_q [$];
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    decoder_scan_sequencer_if bus ();
    assign bus.start     = start;
    assign bus.stop      = stop;
    assign bus.dir       = dir;
    assign bus.mode      = mode;
    assign bus.load_addr = load;
    assign obs[g] = {bus.a2, bus.a1, bus.a0, bus.en, bus.step, bus.wrap, bus.done, bus.busy};

    decoder_scan_sequencer #(
      .TICK_DIV (g + 1)
    ) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus.slave)
    );
  end

  function automatic stim_t mk_stim(input int r, input int st, input int sp,
                                    input int d, input int m, input int la);
    stim_t s;
    s.rst   = 1'(r);
    s.start = 1'(st);
    s.stop  = 1'(sp);
    s.dir   = 1'(d);
    s.mode  = 1'(m);
    s.load  = 3'(la);
    return s;
  endfunction

  function automatic exp_t mk_exp(input int a, input int e, input int st,
                                  input int w, input int dn, input int b);
    exp_t x;
    x.addr = 3'(a);
    x.en   = 1'(e);
    x.step = 1'(st);
    x.wrap = 1'(w);
    x.done = 1'(dn);
    x.busy = 1'(b);
    return x;
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic cyc(input stim_t s, input exp_t e, input string name);
    exp_t want;
    exp_t got;
    rst   = s.rst;
    start = s.start;
    stop  = s.stop;
    dir   = s.dir;
    mode  = s.mode;
    load  = s.load;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    got  = obs[sel];
    checks++;
    if (got === want) begin
      passed++;
    end else begin
      $display("FAIL %s (TICK_DIV=%0d) t=%0t: got %b want %b [addr,en,step,wrap,done,busy]",
               name, int'(sel) + 1, $time, got, want);
    end
  endtask

  initial begin
    stim_t idle_s;
    stim_t rst_s;
    stim_t stop_s;
    exp_t  zero;
    vec_t  tbl [15];
    int    c;
    int    st;
    int    wr;

    idle_s = mk_stim(0, 0, 0, 0, 0, 0);
    rst_s  = mk_stim(1, 0, 0, 0, 0, 0);
    stop_s = mk_stim(0, 0, 1, 0, 0, 0);
    zero   = mk_exp(0, 0, 0, 0, 0, 0);

    // Stop priority, start+stop in idle, start ignored while running (TICK_DIV = 3).
    tbl[0]  = '{mk_stim(1, 0, 0, 0, 0, 0), mk_exp(0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{mk_stim(0, 1, 0, 0, 0, 4), mk_exp(4, 1, 1, 0, 0, 1)};
    tbl[2]  = '{mk_stim(0, 0, 0, 0, 0, 0), mk_exp(4, 1, 0, 0, 0, 1)};
    tbl[3]  = '{mk_stim(0, 0, 0, 0, 0, 0), mk_exp(4, 1, 0, 0, 0, 1)};
    tbl[4]  = '{mk_stim(0, 0, 1, 0, 0, 0), mk_exp(4, 0, 0, 0, 0, 0)};
    tbl[5]  = '{mk_stim(0, 1, 1, 0, 0, 2), mk_exp(4, 0, 0, 0, 0, 0)};
    tbl[6]  = '{mk_stim(0, 0, 0, 0, 0, 0), mk_exp(4, 0, 0, 0, 0, 0)};
    tbl[7]  = '{mk_stim(0, 1, 0, 1, 0, 1), mk_exp(1, 1, 1, 0, 0, 1)};
    tbl[8]  = '{mk_stim(0, 1, 0, 0, 0, 6), mk_exp(1, 1, 0, 0, 0, 1)};
    tbl[9]  = '{mk_stim(0, 1, 0, 0, 0, 6), mk_exp(1, 1, 0, 0, 0, 1)};
    tbl[10] = '{mk_stim(0, 0, 0, 0, 0, 0), mk_exp(0, 1, 1, 0, 0, 1)};
    tbl[11] = '{mk_stim(0, 0, 0, 0, 0, 0), mk_exp(0, 1, 0, 0, 0, 1)};
    tbl[12] = '{mk_stim(0, 0, 0, 0, 0, 0), mk_exp(0, 1, 0, 0, 0, 1)};
    tbl[13] = '{mk_stim(0, 1, 0, 0, 0, 5), mk_exp(7, 1, 1, 1, 0, 1)};
    tbl[14] = '{mk_stim(0, 0, 1, 0, 0, 0), mk_exp(7, 0, 0, 0, 0, 0)};

    sel = 2'd3;
    cyc(rst_s, zero, "reset_state");
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      cyc(idle_s, zero, "idle_after_reset");
    end

    // Reset mid-run at address 5, then an immediate restart.
    sel = 2'd3;
    cyc(mk_stim(0, 1, 0, 0, 0, 5), mk_exp(5, 1, 1, 0, 0, 1), "rst_start");
    cyc(idle_s, mk_exp(5, 1, 0, 0, 0, 1), "rst_run");
    cyc(rst_s, zero, "rst_mid_run");
    cyc(mk_stim(0, 1, 0, 0, 0, 5), mk_exp(5, 1, 1, 0, 0, 1), "rst_restart");
    cyc(idle_s, mk_exp(5, 1, 0, 0, 0, 1), "rst_restart_hold");
    cyc(stop_s, mk_exp(5, 0, 0, 0, 0, 0), "rst_stop");

    // Continuous up from 6, TICK_DIV = 4; final stop lands on a terminal tick.
    sel = 2'd3;
    cyc(rst_s, zero, "cu_reset");
    for (int k = 0; k < 40; k++) begin
      c  = (6 + k / 4) % 8;
      st = (k % 4 == 0) ? 1 : 0;
      wr = (st == 1 && k > 0 && c == 0) ? 1 : 0;
      cyc((k == 0) ? mk_stim(0, 1, 0, 0, 0, 6) : idle_s, mk_exp(c, 1, st, wr, 0, 1), "cont_up");
    end
    cyc(stop_s, mk_exp(7, 0, 0, 0, 0, 0), "cont_up_stop_on_tick");

    // Single pass down from 2, TICK_DIV = 2.
    sel = 2'd1;
    cyc(rst_s, zero, "sp_reset");
    for (int k = 0; k < 16; k++) begin
      c  = (10 - k / 2) % 8;
      st = (k % 2 == 0) ? 1 : 0;
      wr = (st == 1 && k > 0 && c == 7) ? 1 : 0;
      cyc((k == 0) ? mk_stim(0, 1, 0, 1, 1, 2) : idle_s, mk_exp(c, 1, st, wr, 0, 1), "single_down");
    end
    cyc(idle_s, mk_exp(3, 0, 0, 0, 1, 0), "single_done");
    cyc(idle_s, mk_exp(3, 0, 0, 0, 0, 0), "single_after_done");
    cyc(idle_s, mk_exp(3, 0, 0, 0, 0, 0), "single_hold");

    // TICK_DIV = 1: new address and step every cycle.
    sel = 2'd0;
    cyc(rst_s, zero, "td1_reset");
    for (int k = 0; k < 20; k++) begin
      c  = k % 8;
      wr = (k > 0 && c == 0) ? 1 : 0;
      cyc((k == 0) ? mk_stim(0, 1, 0, 0, 0, 0) : idle_s, mk_exp(c, 1, 1, wr, 0, 1), "td1_cont");
    end
    cyc(stop_s, mk_exp(3, 0, 0, 0, 0, 0), "td1_stop");

    sel = 2'd2;
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].s, tbl[i].e, $sformatf("tbl_td3_row%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/decoder_scan_sequencer.md
# decoder_scan_sequencer

Generates the 3-bit select address (a2, a1, a0) and enable that drive the 3-to-8 one-hot decoder. It steps the address through all eight codes, up or down, holding each code for a programmable number of clock cycles. It supports continuous wrap-around scanning (display/row multiplexing) and single-pass sweeps. It issues step, wrap and done pulses so downstream logic can stay aligned with the active decoder line.

## Interface
- TICK_DIV, 4: clock cycles each address is held; legal range 1..65535
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- start  in  1  one-cycle request to begin a scan
- stop  in  1  one-cycle request to abort and return to idle
- dir  in  1  0 = count up, 1 = count down; sampled only when start is accepted
- mode  in  1  0 = continuous (wrap forever), 1 = single pass (8 codes then stop); sampled only when start is accepted
- load_addr  in  3  first address of the scan; sampled only when start is accepted
- a2, a1, a0  out  1 each  registered address to decoder, a2 = MSB
- en  out  1  address valid / decoder enable
- step  out  1  one-cycle pulse, high in the first cycle each new address is presented
- wrap  out  1  one-cycle pulse, coincident with step, when address went 7→0 (up) or 0→7 (down)
- done  out  1  one-cycle pulse at end of a single pass
- busy  out  1  high while in RUN

## Operation
- States: IDLE, RUN. Encoding: IDLE = 0, RUN = 1.
- Reset (any state, any cycle): state = IDLE. {a2,a1,a0} = 0. en, step, wrap, done, busy = 0. Prescale counter = 0. Pass counter = 0. Latched dir and mode = 0.
- IDLE:
  - Outputs en = 0 and busy = 0. The address register holds its last value.
  - On start = 1 and stop = 0: latch dir and mode, load address = load_addr, clear prescale and pass counters, step = 1, go to RUN.
- RUN:
  - The prescale counter counts 0..TICK_DIV-1.
  - At terminal count (TICK_DIV-1), with continuous mode or pass counter < 7:
    - Address advances by +1 (dir = 0) or -1 (dir = 1), modulo 8.
    - step = 1, and wrap = 1 if the transition crossed 7/0.
    - Pass counter increments (saturating, only meaningful in single-pass mode).
    - Prescale counter restarts at 0.
  - At terminal count in single-pass mode with pass counter = 7:
    - No advance. Go to IDLE; done = 1, en = 0, busy = 0.
    - The address holds at the last code visited.
- stop = 1 in RUN: go to IDLE next edge with en = 0. No done, no step. The address holds.
- stop has priority over a same-cycle terminal tick and over start.
- start while in RUN is ignored. No restart, and dir/mode/load_addr are not re-sampled.
- start and stop together in IDLE: stop wins, remain IDLE.
- Pulses step, wrap and done are registered and last exactly one cycle.

## Timing
- start sampled high at edge N → at edge N+1 (the cycle after):
  - en = 1, busy = 1, step = 1, address = load_addr.
  - wrap = 0 on this initial load.
- Each address is presented for exactly TICK_DIV cycles. With TICK_DIV = 1 the address changes every cycle and step stays high continuously while in RUN.
- Single pass: en high for exactly 8×TICK_DIV cycles. done is high in the first cycle en is low.
- stop sampled at edge N → en = 0 and busy = 0 from edge N+1. Address unchanged.
- reset sampled at edge N overrides all inputs. All outputs take reset values from edge N+1.
- All outputs are driven directly from flops. No combinational path from inputs to outputs.

## Structure
- Shared package/header holds:
  - ADDR_W = 3.
  - State encodings ST_IDLE and ST_RUN.
  - DIR_UP = 0, DIR_DOWN = 1.
  - MODE_CONT = 0, MODE_SINGLE = 1.
- One sub-module, tick_divider:
  - Parameterised by TICK_DIV.
  - Inputs clk, reset, clear, enable; output tick, high at terminal count.
  - The sequencer instantiates it and drives clear on start acceptance and on every tick.
- The FSM, address register and pass counter stay in the top module.

## Test plan
- Reset: TICK_DIV = 4, assert reset mid-RUN at address 5 → next cycle address = 0 and en/busy/step/wrap/done = 0. start in the following cycle behaves normally.
- Continuous up: TICK_DIV = 4, load_addr = 6, dir = 0, mode = 0.
  - Expected sequence: 6,7,0,1,… with each code held 4 cycles.
  - step fires every 4 cycles; wrap fires only at the 7→0 step.
- Single pass down: TICK_DIV = 2, load_addr = 2, dir = 1, mode = 1.
  - Expected sequence: 2,1,0,7,6,5,4,3, with wrap on 0→7.
  - en high exactly 16 cycles; done pulses once as en falls; address holds at 3.
- TICK_DIV = 1: start with load_addr = 0, up, continuous → address increments every cycle, step constantly high, wrap every 8 cycles.
- Stop priority: TICK_DIV = 3, stop asserted in the terminal-tick cycle at address 4 → next cycle en = 0 and address = 4, with no step and no done. start + stop together in IDLE → stays IDLE.
- start while RUN: assert start with different dir/load_addr mid-scan → sequence and latched dir unchanged, no extra step.
